// File: rtl/arch_out_tx.sv
`default_nettype none
// ============================================================================
// Module      : arch_out_tx
// Description : Byte FIFO feeding an 8N1 serial transmitter (LSB first).
// Revision    : 1.0 - initial release
// ============================================================================
module arch_out_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     out_en,
    input  logic [7:0]               out_value,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;

    logic [1:0]      r_state;
    logic            r_tx;
    logic [7:0]      r_shift;
    logic [c_CW-1:0] r_cyc;
    logic [2:0]      r_bit;

    logic [1:0]      w_state_nxt;
    logic            w_tx_nxt;
    logic [7:0]      w_shift_nxt;
    logic [c_CW-1:0] w_cyc_nxt;
    logic [2:0]      w_bit_nxt;

    logic w_pop;
    logic w_push;
    logic w_bit_end;

    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    assign w_pop     = (r_state == c_ST_IDLE) && (r_count != '0);
    assign w_push    = out_en && ((r_count != c_FULL) || w_pop);
    assign w_bit_end = (r_cyc == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (out_en && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= out_value;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_shift_nxt = r_shift;
        w_cyc_nxt   = r_cyc;
        w_bit_nxt   = r_bit;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_pop) begin
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_cyc_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_ST_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = c_ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cyc_nxt = r_cyc + c_CW'(1);
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    w_cyc_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // Next bit is presented straight from the shifter.
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cyc_nxt = r_cyc + c_CW'(1);
                end
            end
            c_ST_STOP: begin
                if (w_bit_end) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = c_ST_IDLE;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cyc_nxt = r_cyc + c_CW'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_cyc   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            r_cyc   <= w_cyc_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != c_ST_IDLE) || (r_count != '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_arch_out_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_arch_out_tx
// Description : Directed + random stimulus against a queue/waveform model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arch_out_tx;

    localparam int C = 4;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_en = 1'b0;
    logic [7:0] out_value = 8'h00;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    // Model: queue of waiting bytes, position inside the current frame (-1 = idle).
    logic [7:0] m_q[$];
    logic [7:0] m_cur = 8'h00;
    int         m_pos = -1;
    logic       m_ovf = 1'b0;
    int         peak = 0;
    bit         hit = 0;

    arch_out_tx #(.DEPTH(D), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .out_en     (out_en),
        .out_value  (out_value),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx();
        logic [7:0] b;
        b = m_cur;
        if (m_pos < 0)          return 1'b1;
        else if (m_pos < C)     return 1'b0;
        else if (m_pos < 9 * C) return b[(m_pos - C) / C];
        else                    return 1'b1;
    endfunction

    task automatic step(input logic r, input logic en, input logic [7:0] v);
        @(negedge clk);
        rst = r; out_en = en; out_value = v;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_pos = -1;
            m_ovf = 1'b0;
        end else begin
            if (m_pos < 0) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == 10 * C) m_pos = -1;
            end
            if (en) begin
                if (m_q.size() < D) m_q.push_back(v);
                else                m_ovf = 1'b1;
            end
        end
        #1;
        check("tx", 32'(tx), 32'(exp_tx()));
        check("busy", 32'(busy), 32'((m_pos >= 0) || (m_q.size() != 0)));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b0, 8'h00);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);

        // Single byte 0xA5
        step(1'b0, 1'b1, 8'hA5);
        idle(40);
        check("single_busy_end", 32'(busy), 32'd1);
        idle(1);
        check("single_idle", 32'(busy), 32'd0);
        idle(4);

        // Burst of three on consecutive cycles
        peak = 0;
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        idle(3 * 41);
        check("burst3_peak", 32'(peak), 32'd2);
        check("burst3_done", 32'(busy), 32'd0);

        // Ten bytes while idle: tenth is dropped
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom));
        check("burst10_ovf", 32'(overflow), 32'd1);
        check("burst10_count", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
        check("ovf_sticky", 32'(overflow), 32'd1);
        idle(9 * 41 + 5);

        // Push landing exactly on the pop edge of a full FIFO
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_pos < 0 && m_q.size() == D) begin
                hit = 1;
                step(1'b0, 1'b1, 8'($urandom));
                check("full_pop_count", 32'(fifo_count), 32'd8);
                check("full_pop_ovf", 32'(overflow), 32'd0);
            end else begin
                idle(1);
            end
        end
        check("full_pop_reached", 32'(hit), 32'd1);

        // Reset in the middle of a 0xFF data phase with three queued
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
        idle(10);
        check("pre_rst_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        idle(50);

        // Random traffic across twenty frames, then drain
        for (int i = 0; i < 20 * 41; i++)
            step(1'b0, ($urandom_range(0, 29) == 0), 8'($urandom));
        idle(9 * 41 + 5);
        check("drained", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
